// File: rtl/axi_lite_bridge_pkg.sv
// Shared types and constants for the core-to-AXI4-Lite bridge.
// Response codes, FSM state type and bridge defaults.
package lexington;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;
  localparam int DEFAULT_AXI_TIMEOUT    = 255;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    RESP,
    DONE,
    DRAIN
  } axi_bridge_state_t;

  function automatic logic resp_is_fault(
    input logic [1:0] resp
  );
    return (resp == AXI_RESP_SLVERR) ||
           (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_bridge.sv
// Single-word core data port to AXI4-Lite manager bridge.
// One AXI transaction per request, with timeout and drain recovery.
module axi_lite_bridge
  import lexington::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axi_rd_en,
  input  logic                      axi_wr_en,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
  input  logic [31:0]               wr_data,
  input  logic [3:0]                wr_strobe,
  output logic [31:0]               axi_rd_data,
  output logic                      axi_access_fault,
  output logic                      axi_busy,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [31:0]               m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT =
    CW'(TIMEOUT_CYCLES - 1);

  axi_bridge_state_t r_state;

  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic                      r_is_wr;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      r_arvalid;
  logic                      r_bready;
  logic                      r_rready;
  logic [31:0]               r_rd_data;
  logic                      r_fault;
  logic [CW-1:0]             r_cnt;
  logic                      r_drain;
  logic                      r_need_resp;

  logic w_req;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_r_hs;
  logic w_b_hs;
  logic w_resp_hs;
  logic w_addr_clear;
  logic w_resp_fault;
  logic w_timeout;

  assign w_req   = axi_rd_en | axi_wr_en;
  assign w_ar_hs = r_arvalid & m_axi_arready;
  assign w_aw_hs = r_awvalid & m_axi_awready;
  assign w_w_hs  = r_wvalid & m_axi_wready;
  assign w_r_hs  = r_rready & m_axi_rvalid;
  assign w_b_hs  = r_bready & m_axi_bvalid;

  assign w_resp_hs = w_r_hs | w_b_hs;

  // True when no address/data valid remains pending after this edge
  assign w_addr_clear =
    ~((r_arvalid & ~m_axi_arready) |
      (r_awvalid & ~m_axi_awready) |
      (r_wvalid  & ~m_axi_wready));

  assign w_resp_fault = r_is_wr ?
    resp_is_fault(m_axi_bresp) :
    resp_is_fault(m_axi_rresp);

  assign w_timeout =
    (TIMEOUT_CYCLES != 0) && (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_is_wr     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rd_data   <= '0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
      r_drain     <= 1'b0;
      r_need_resp <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (w_ar_hs) r_arvalid <= 1'b0;
      if (w_aw_hs) r_awvalid <= 1'b0;
      if (w_w_hs)  r_wvalid  <= 1'b0;
      if (w_r_hs)  r_rready  <= 1'b0;
      if (w_b_hs)  r_bready  <= 1'b0;
      if (w_resp_hs) r_need_resp <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state     <= ADDR;
            r_is_wr     <= axi_wr_en;
            r_addr      <= axi_addr;
            r_wdata     <= wr_data;
            r_wstrb     <= wr_strobe;
            r_cnt       <= '0;
            r_drain     <= 1'b0;
            r_need_resp <= 1'b1;
            if (axi_wr_en) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_arvalid <= 1'b1;
            end
          end
        end

        ADDR: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_timeout) begin
            r_state <= DONE;
            r_fault <= 1'b1;
            r_drain <= 1'b1;
          end else if (w_addr_clear) begin
            r_state <= RESP;
            if (r_is_wr) r_bready <= 1'b1;
            else         r_rready <= 1'b1;
          end
        end

        RESP: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_resp_hs) begin
            r_state <= DONE;
            r_fault <= w_resp_fault;
            if (!r_is_wr) r_rd_data <= m_axi_rdata;
          end else if (w_timeout) begin
            r_state <= DONE;
            r_fault <= 1'b1;
            r_drain <= 1'b1;
          end
        end

        DONE: begin
          r_state <= r_drain ? DRAIN : IDLE;
          if (r_drain && w_addr_clear &&
              r_need_resp && !w_resp_hs) begin
            if (r_is_wr) r_bready <= 1'b1;
            else         r_rready <= 1'b1;
          end
        end

        DRAIN: begin
          // Late response is absorbed here and never reaches the core
          if (w_resp_hs || !r_need_resp) begin
            r_state <= IDLE;
            r_drain <= 1'b0;
          end else if (w_addr_clear) begin
            if (r_is_wr) r_bready <= 1'b1;
            else         r_rready <= 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign axi_busy = w_req & (r_state != DONE);

  assign axi_rd_data      = r_rd_data;
  assign axi_access_fault = r_fault;

  assign m_axi_awaddr  = r_addr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_bridge.sv
// Bench for axi_lite_bridge: vector table, hand-written corner
// sequences and randomized traffic against a delay-driven slave.
module tb_axi_lite_bridge;
  import lexington::*;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          axi_rd_en = 1'b0;
  logic          axi_wr_en = 1'b0;
  logic [AW-1:0] axi_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [3:0]    wr_strobe = '0;
  logic [31:0]   axi_rd_data;
  logic          axi_access_fault;
  logic          axi_busy;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [31:0]   m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  axi_lite_bridge #(
    .AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi_rd_en(axi_rd_en),
    .axi_wr_en(axi_wr_en),
    .axi_addr(axi_addr),
    .wr_data(wr_data),
    .wr_strobe(wr_strobe),
    .axi_rd_data(axi_rd_data),
    .axi_access_fault(axi_access_fault),
    .axi_busy(axi_busy),
    .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // Slave behaviour per transaction: ready delay, data-ready delay,
  // response delay, response code and read data.
  typedef struct {
    int         ad;
    int         wd;
    int         rd;
    logic [1:0] resp;
    logic [31:0] data;
  } scfg_t;

  scfg_t cfgs [256];
  int    wp = 0;

  int          rp = 0;
  scfg_t       cur = '{0, 0, 0, 2'b00, 32'h0};
  bit          act = 0;
  bit          is_rd = 0;
  bit          a_ok = 0;
  bit          w_ok = 0;
  int          a_cnt = 0;
  int          w_cnt = 0;
  int          r_cnt = 0;
  logic [31:0] obs_addr = '0;
  logic [31:0] obs_data = '0;
  logic [3:0]  obs_strb = '0;
  logic [2:0]  obs_prot = '0;
  int          ar_count = 0;

  always @(posedge clk) begin
    if (rst) begin
      act = 0;
    end else if (act) begin
      if (is_rd ? (m_axi_rvalid && m_axi_rready)
                : (m_axi_bvalid && m_axi_bready)) begin
        act = 0;
      end else begin
        if (a_ok && (is_rd || w_ok)) r_cnt++;
        if (!a_ok) begin
          if (is_rd && m_axi_arvalid && m_axi_arready) begin
            a_ok = 1;
            obs_addr = m_axi_araddr;
            obs_prot = m_axi_arprot;
            ar_count++;
          end else if (!is_rd && m_axi_awvalid && m_axi_awready) begin
            a_ok = 1;
            obs_addr = m_axi_awaddr;
            obs_prot = m_axi_awprot;
          end else begin
            a_cnt++;
          end
        end
        if (!is_rd && !w_ok) begin
          if (m_axi_wvalid && m_axi_wready) begin
            w_ok = 1;
            obs_data = m_axi_wdata;
            obs_strb = m_axi_wstrb;
          end else begin
            w_cnt++;
          end
        end
      end
    end
    #1;
    if (!rst && !act &&
        (m_axi_arvalid || m_axi_awvalid || m_axi_wvalid)) begin
      if (rp < wp) begin
        cur = cfgs[rp];
        rp++;
      end else begin
        cur = '{0, 0, 0, 2'b00, 32'h0};
      end
      act = 1;
      is_rd = m_axi_arvalid;
      a_ok = 0;
      w_ok = 0;
      a_cnt = 0;
      w_cnt = 0;
      r_cnt = 0;
    end
    m_axi_arready = act && is_rd && m_axi_arvalid && !a_ok &&
                    (a_cnt >= cur.ad);
    m_axi_awready = act && !is_rd && m_axi_awvalid && !a_ok &&
                    (a_cnt >= cur.ad);
    m_axi_wready  = act && !is_rd && m_axi_wvalid && !w_ok &&
                    (w_cnt >= cur.wd);
    m_axi_rvalid  = act && is_rd && a_ok && (r_cnt >= cur.rd);
    m_axi_bvalid  = act && !is_rd && a_ok && w_ok &&
                    (r_cnt >= cur.rd);
    m_axi_rdata   = cur.data;
    m_axi_rresp   = cur.resp;
    m_axi_bresp   = cur.resp;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act_v,
                       input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_txn(input bit wr,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [3:0] strb,
                        input scfg_t c,
                        output int stall,
                        output logic flt,
                        output logic [31:0] rdv,
                        output logic flt_after);
    if (wp < 256) begin
      cfgs[wp] = c;
      wp++;
    end
    axi_addr = addr;
    wr_data = wdata;
    wr_strobe = strb;
    axi_wr_en = wr;
    axi_rd_en = !wr;
    #1;
    stall = 0;
    while (axi_busy && stall < 60) begin
      stall++;
      tick();
    end
    flt = axi_access_fault;
    rdv = axi_rd_data;
    tick();
    axi_wr_en = 1'b0;
    axi_rd_en = 1'b0;
    flt_after = axi_access_fault;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ad;
    int          wd;
    int          rd;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_stall;
    bit          exp_fault;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vt [7];
    scfg_t       c;
    int          stall;
    logic        flt;
    logic        flta;
    logic [31:0] rdv;
    logic [31:0] model_rd;
    int          exp_stall;
    int          ar0;
    int          fcount;
    int          fcycle;

    vt[0] = '{0, 32'h10, 32'h0, 4'h0, 0, 0, 0,
              AXI_RESP_OKAY, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF};
    vt[1] = '{1, 32'h20, 32'h12345678, 4'b0011, 2, 0, 0,
              AXI_RESP_OKAY, 32'h0, 5, 0, 32'hDEADBEEF};
    vt[2] = '{0, 32'h14, 32'h0, 4'h0, 0, 0, 0,
              AXI_RESP_SLVERR, 32'h11111111, 3, 1, 32'h11111111};
    vt[3] = '{0, 32'h18, 32'h0, 4'h0, 1, 0, 2,
              AXI_RESP_DECERR, 32'h22223333, 6, 1, 32'h22223333};
    vt[4] = '{1, 32'h24, 32'hAABBCCDD, 4'hF, 0, 2, 1,
              AXI_RESP_SLVERR, 32'h0, 6, 1, 32'h22223333};
    vt[5] = '{0, 32'h1C, 32'h0, 4'h0, 0, 0, 1,
              AXI_RESP_EXOKAY, 32'h0F0F0F0F, 4, 0, 32'h0F0F0F0F};
    vt[6] = '{1, 32'h28, 32'h55AA55AA, 4'b1000, 1, 1, 0,
              AXI_RESP_EXOKAY, 32'h0, 4, 0, 32'h0F0F0F0F};

    rst = 1'b1;
    repeat (3) tick();
    check("rst arvalid", 32'(m_axi_arvalid), 0);
    check("rst awvalid", 32'(m_axi_awvalid), 0);
    check("rst wvalid", 32'(m_axi_wvalid), 0);
    check("rst rready", 32'(m_axi_rready), 0);
    check("rst bready", 32'(m_axi_bready), 0);
    check("rst rd_data", axi_rd_data, 0);
    check("rst fault", 32'(axi_access_fault), 0);
    check("rst busy", 32'(axi_busy), 0);
    rst = 1'b0;
    tick();

    // Zero-wait read, cycle by cycle
    cfgs[wp] = '{0, 0, 0, AXI_RESP_OKAY, 32'hDEADBEEF};
    wp++;
    axi_addr = 32'h10;
    axi_rd_en = 1'b1;
    #1;
    check("rd N busy", 32'(axi_busy), 1);
    check("rd N arvalid", 32'(m_axi_arvalid), 0);
    tick();
    check("rd N+1 arvalid", 32'(m_axi_arvalid), 1);
    check("rd N+1 araddr", m_axi_araddr, 32'h10);
    check("rd N+1 arprot", 32'(m_axi_arprot), 0);
    check("rd N+1 busy", 32'(axi_busy), 1);
    tick();
    check("rd N+2 arvalid", 32'(m_axi_arvalid), 0);
    check("rd N+2 rready", 32'(m_axi_rready), 1);
    check("rd N+2 busy", 32'(axi_busy), 1);
    tick();
    check("rd N+3 busy", 32'(axi_busy), 0);
    check("rd N+3 data", axi_rd_data, 32'hDEADBEEF);
    check("rd N+3 fault", 32'(axi_access_fault), 0);
    tick();
    axi_rd_en = 1'b0;
    check("rd N+4 fault", 32'(axi_access_fault), 0);

    // Write where W handshakes two cycles before AW
    cfgs[wp] = '{2, 0, 0, AXI_RESP_OKAY, 32'h0};
    wp++;
    axi_addr = 32'h20;
    wr_data = 32'h12345678;
    wr_strobe = 4'b0011;
    axi_wr_en = 1'b1;
    tick();
    check("wr N+1 awvalid", 32'(m_axi_awvalid), 1);
    check("wr N+1 wvalid", 32'(m_axi_wvalid), 1);
    check("wr N+1 wstrb", 32'(m_axi_wstrb), 32'h3);
    tick();
    check("wr N+2 wvalid", 32'(m_axi_wvalid), 0);
    check("wr N+2 awvalid", 32'(m_axi_awvalid), 1);
    tick();
    check("wr N+3 awvalid", 32'(m_axi_awvalid), 1);
    tick();
    check("wr N+4 awvalid", 32'(m_axi_awvalid), 0);
    check("wr N+4 bready", 32'(m_axi_bready), 1);
    tick();
    check("wr N+5 busy", 32'(axi_busy), 0);
    check("wr N+5 fault", 32'(axi_access_fault), 0);
    check("wr obs strb", 32'(obs_strb), 32'h3);
    check("wr obs data", obs_data, 32'h12345678);
    tick();
    axi_wr_en = 1'b0;

    for (int i = 0; i < 7; i++) begin
      c = '{vt[i].ad, vt[i].wd, vt[i].rd, vt[i].resp, vt[i].rdata};
      do_txn(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, c,
             stall, flt, rdv, flta);
      check($sformatf("vec%0d stall", i), stall, vt[i].exp_stall);
      check($sformatf("vec%0d fault", i), 32'(flt),
            32'(vt[i].exp_fault));
      check($sformatf("vec%0d rd_data", i), rdv, vt[i].exp_rd);
      check($sformatf("vec%0d fault after", i), 32'(flta), 0);
      check($sformatf("vec%0d addr", i), obs_addr, vt[i].addr);
      check($sformatf("vec%0d prot", i), 32'(obs_prot), 0);
      if (vt[i].wr) begin
        check($sformatf("vec%0d wdata", i), obs_data, vt[i].wdata);
        check($sformatf("vec%0d wstrb", i), 32'(obs_strb),
              32'(vt[i].strb));
      end
    end
    model_rd = 32'h0F0F0F0F;

    // Randomized traffic against the delay-rule model
    for (int k = 0; k < 60; k++) begin
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  st;
      int          gap;
      wr = bit'($urandom_range(0, 1));
      addr = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      c.ad = $urandom_range(0, 2);
      c.wd = $urandom_range(0, 2);
      c.rd = $urandom_range(0, 2);
      c.resp = 2'($urandom_range(0, 3));
      c.data = $urandom;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      exp_stall = 3 + c.rd +
        (wr ? ((c.ad > c.wd) ? c.ad : c.wd) : c.ad);
      if (!wr) model_rd = c.data;
      do_txn(wr, addr, wd, st, c, stall, flt, rdv, flta);
      check($sformatf("rnd%0d stall", k), stall, exp_stall);
      check($sformatf("rnd%0d fault", k), 32'(flt),
            32'((c.resp == 2'b10) || (c.resp == 2'b11)));
      check($sformatf("rnd%0d rd_data", k), rdv, model_rd);
      check($sformatf("rnd%0d fault after", k), 32'(flta), 0);
      check($sformatf("rnd%0d addr", k), obs_addr, addr);
      if (wr) begin
        check($sformatf("rnd%0d wdata", k), obs_data, wd);
        check($sformatf("rnd%0d wstrb", k), 32'(obs_strb), 32'(st));
      end
    end

    // Timeout, then a back-to-back read that waits out the drain
    ar0 = ar_count;
    c = '{18, 0, 0, AXI_RESP_OKAY, 32'hBAD0BAD0};
    do_txn(1'b0, 32'h40, 32'h0, 4'h0, c, stall, flt, rdv, flta);
    check("to stall", stall, TO + 1);
    check("to fault", 32'(flt), 1);
    check("to rd_data held", rdv, model_rd);
    check("to fault after", 32'(flta), 0);
    c = '{0, 0, 0, AXI_RESP_OKAY, 32'h600D600D};
    do_txn(1'b0, 32'h44, 32'h0, 4'h0, c, stall, flt, rdv, flta);
    check("drain stall", stall, 14);
    check("drain fault", 32'(flt), 0);
    check("drain rd_data", rdv, 32'h600D600D);
    check("drain addr", obs_addr, 32'h44);
    check("drain ar count", ar_count - ar0, 2);

    // Reset while waiting for R
    cfgs[wp] = '{0, 0, 3, AXI_RESP_OKAY, 32'h77777777};
    wp++;
    axi_addr = 32'h50;
    axi_rd_en = 1'b1;
    tick();
    tick();
    check("rstresp rready pre", 32'(m_axi_rready), 1);
    rst = 1'b1;
    axi_rd_en = 1'b0;
    tick();
    check("rstresp arvalid", 32'(m_axi_arvalid), 0);
    check("rstresp awvalid", 32'(m_axi_awvalid), 0);
    check("rstresp wvalid", 32'(m_axi_wvalid), 0);
    check("rstresp rready", 32'(m_axi_rready), 0);
    check("rstresp bready", 32'(m_axi_bready), 0);
    check("rstresp rd_data", axi_rd_data, 0);
    check("rstresp busy", 32'(axi_busy), 0);
    rst = 1'b0;
    tick();

    // Core withdraws its request during ADDR
    ar0 = ar_count;
    cfgs[wp] = '{2, 0, 0, AXI_RESP_SLVERR, 32'h12121212};
    wp++;
    axi_addr = 32'h60;
    axi_rd_en = 1'b1;
    tick();
    axi_rd_en = 1'b0;
    fcount = 0;
    fcycle = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (axi_access_fault) begin
        fcount++;
        fcycle = i;
      end
    end
    check("drop done count", fcount, 1);
    check("drop done cycle", fcycle, 4);
    check("drop ar count", ar_count - ar0, 1);
    check("drop busy", 32'(axi_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_bridge.md
# axi_lite_bridge

Responder for the core's simple AXI-side data port: accepts single-word `axi_rd_en`/`axi_wr_en` requests, stalls the core with `axi_busy`, and runs one AXI4-Lite manager transaction per request toward the peripheral interconnect. It returns read data and an access-fault flag on the completion cycle. It sits between the core and the AXI4-Lite peripheral fabric (GPIO, UART, timers).

## Interface
- `AXI_ADDR_WIDTH`, default `DEFAULT_AXI_ADDR_WIDTH`: address width on both sides.
- `TIMEOUT_CYCLES`, default 255: cycles in ADDR+RESP before declaring fault; 0 disables timeout.

Ports (clock and reset first):
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `axi_rd_en` input 1: core read request.
- `axi_wr_en` input 1: core write request.
- `axi_addr` input AXI_ADDR_WIDTH: byte address.
- `wr_data` input 32: write data.
- `wr_strobe` input 4: byte strobes.
- `axi_rd_data` output 32: read data.
- `axi_access_fault` output 1: fault, valid on completion cycle only.
- `axi_busy` output 1: core stall.
- `m_axi_awaddr`/`m_axi_awprot`/`m_axi_awvalid` output AXI_ADDR_WIDTH/3/1; `m_axi_awready` input 1.
- `m_axi_wdata`/`m_axi_wstrb`/`m_axi_wvalid` output 32/4/1; `m_axi_wready` input 1.
- `m_axi_bresp` input 2, `m_axi_bvalid` input 1, `m_axi_bready` output 1.
- `m_axi_araddr`/`m_axi_arprot`/`m_axi_arvalid` output AXI_ADDR_WIDTH/3/1; `m_axi_arready` input 1.
- `m_axi_rdata` input 32, `m_axi_rresp` input 2, `m_axi_rvalid` input 1, `m_axi_rready` output 1.

## Operation
- States: IDLE, ADDR, RESP, DONE, DRAIN.
- IDLE: `req = axi_rd_en | axi_wr_en`. On req, latch addr/data/strobe/direction and go to ADDR. Write takes priority if both are asserted.
- ADDR, read: `arvalid=1` until `arready`, then go to RESP.
- ADDR, write: `awvalid` and `wvalid` assert together. Each deasserts independently on its own handshake, tracked by `aw_done`/`w_done`. Go to RESP once both are done; this works in any order, including the same cycle.
- RESP: `rready`/`bready=1`. On handshake, capture `rdata` (reads only) and fault = `resp[1]` (SLVERR/DECERR), then go to DONE.
- DONE: lasts one cycle. Present the captured fault, then go to IDLE.
- Timeout: a counter runs in ADDR and RESP and clears on entering ADDR. At `TIMEOUT_CYCLES` it sets fault, goes to DONE, then goes to DRAIN instead of IDLE.
- DRAIN: keeps any still-pending valid asserted until its handshake, then holds `rready`/`bready=1` until the response arrives. The response is discarded, then go to IDLE. A new request is not started in DRAIN; it stalls.
- `axi_busy = req & (state != DONE)`; combinational.
- If the core drops its request before DONE, the AXI transaction still completes and the result is discarded. DONE still occurs for one cycle.
- `awprot`/`arprot` = 3'b000.
- `axi_rd_data`: registered, updated only on an R handshake, held otherwise.
- `axi_access_fault`: 0 except in DONE.
- Reset (rst=1 at a clock edge) returns to IDLE from any state, including mid-transaction. Reset values: all valids/readies 0, `axi_rd_data`=0, fault=0, counter=0. Abandoning an in-flight AXI transaction on reset is permitted; the system reset also resets the fabric.

## Timing
- Request at cycle N, with `axi_busy`=1 at N. `arvalid`/`awvalid`/`wvalid` are registered and first high at N+1.
- Zero-wait-state slave (ready at N+1, valid response at N+2): DONE at N+3, with `axi_busy`=0 and data/fault valid at N+3.
- Minimum stall: 3 cycles. A back-to-back request enters IDLE at N+4 and issues at N+5.
- Each extra wait cycle on ready or valid adds one cycle.
- Timeout: DONE is reached at exactly `TIMEOUT_CYCLES` cycles after entering ADDR.
- All AXI outputs are registered. Only `axi_busy` is combinational from the request inputs.

## Structure
- `lexington` package gains:
  - `axi_bridge_state_t`: enum IDLE/ADDR/RESP/DONE/DRAIN.
  - `AXI_RESP_OKAY`=2'b00, `AXI_RESP_EXOKAY`=2'b01, `AXI_RESP_SLVERR`=2'b10, `AXI_RESP_DECERR`=2'b11.
  - `DEFAULT_AXI_TIMEOUT`=255.
- No sub-module: the FSM, latches and timeout counter are kept inline.

## Test plan
- Read at 0x0000_0010; slave asserts arready at once and returns rvalid next cycle with rdata=0xDEAD_BEEF, OKAY -> busy high for 3 cycles; DONE shows rd_data=0xDEAD_BEEF and fault=0.
- Write 0x1234_5678, strobe 4'b0011; slave gives wready 2 cycles before awready -> wvalid drops first and awvalid is held. B OKAY -> fault=0; wstrb observed as 4'b0011.
- Read returning SLVERR (2'b10) -> fault=1 for exactly the DONE cycle, then 0.
- TIMEOUT_CYCLES=8; slave never asserts arready until cycle 20 -> DONE with fault=1 at 8 cycles. A back-to-back request stalls in DRAIN until the late R is absorbed, then issues normally.
- rst=1 asserted while in RESP -> next cycle all valids/readies are 0, state is IDLE, rd_data=0.
- Core drops axi_rd_en during ADDR -> transaction completes and DONE occurs for one cycle; no new AR is issued.
